// File: rtl/exe_stage_mc_if.sv
// Bundle between the ID/EX register, the execute stage and the EXE/MEM register.
// The stage itself uses the slave view; the upstream/downstream side uses master.
interface exe_stage_mc_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             wb_en_in;
  logic             mem_r_en_in;
  logic             mem_w_en_in;
  logic             b_in;
  logic             s_in;
  logic             i_in;
  logic [3:0]       exe_cmd_in;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] val_rn_in;
  logic [WIDTH-1:0] val_rm_in;
  logic [11:0]      shift_operand_in;
  logic [23:0]      imm24_in;
  logic [3:0]       dest_in;

  logic             busy;
  logic             out_valid;
  logic             wb_en_out;
  logic             mem_r_en_out;
  logic             mem_w_en_out;
  logic [WIDTH-1:0] alu_res_out;
  logic [WIDTH-1:0] val_rm_out;
  logic [3:0]       dest_out;
  logic [3:0]       status_out;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_addr;

  modport master (
    output flush, in_valid, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, i_in,
           exe_cmd_in, pc_in, val_rn_in, val_rm_in, shift_operand_in, imm24_in, dest_in,
    input  busy, out_valid, wb_en_out, mem_r_en_out, mem_w_en_out, alu_res_out,
           val_rm_out, dest_out, status_out, branch_taken, branch_addr
  );

  modport slave (
    input  flush, in_valid, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, i_in,
           exe_cmd_in, pc_in, val_rn_in, val_rm_in, shift_operand_in, imm24_in, dest_in,
    output busy, out_valid, wb_en_out, mem_r_en_out, mem_w_en_out, alu_res_out,
           val_rm_out, dest_out, status_out, branch_taken, branch_addr
  );
endinterface

// File: rtl/exe_stage_mc.sv
// Multi-cycle ARM execute stage: Val2 shifter, ALU, NZCV register, shift-add
// multiplier with busy handshake and a registered EXE/MEM bundle.
module exe_stage_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic           clk,
  input logic           rst,
  exe_stage_mc_if.slave bus
);
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] rm_hold_reg, rm_hold_next;
  logic [3:0]       dest_hold_reg, dest_hold_next;
  logic [3:0]       ctl_hold_reg, ctl_hold_next;   // {wb, mem_r, mem_w, s}
  logic             out_valid_reg, out_valid_next;
  logic             wb_en_reg, wb_en_next;
  logic             mem_r_reg, mem_r_next;
  logic             mem_w_reg, mem_w_next;
  logic [WIDTH-1:0] alu_res_reg, alu_res_next;
  logic [WIDTH-1:0] val_rm_reg, val_rm_next;
  logic [3:0]       dest_reg, dest_next;
  logic [3:0]       status_reg, status_next;
  logic             busy_int;

  function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] v, input logic [CNT_W-1:0] a);
    // a shift by WIDTH yields 0, so a == 0 needs no special case
    return (v >> a) | (v << (WIDTH - int'(a)));
  endfunction

  logic [4:0]       shift_imm;
  logic [1:0]       shift_type;
  logic [CNT_W-1:0] imm_rot;
  logic [CNT_W-1:0] rm_rot;
  logic [WIDTH-1:0] val2;

  assign shift_imm  = bus.shift_operand_in[11:7];
  assign shift_type = bus.shift_operand_in[6:5];
  assign imm_rot    = CNT_W'(32'({bus.shift_operand_in[11:8], 1'b0}) % WIDTH);
  assign rm_rot     = CNT_W'(32'(shift_imm) % WIDTH);

  always_comb begin
    val2 = '0;
    if (bus.mem_r_en_in || bus.mem_w_en_in) begin
      val2 = WIDTH'(bus.shift_operand_in);
    end else if (bus.i_in) begin
      val2 = ror(WIDTH'(bus.shift_operand_in[7:0]), imm_rot);
    end else begin
      case (shift_type)
        2'b00:   val2 = bus.val_rm_in << shift_imm;
        2'b01:   val2 = bus.val_rm_in >> shift_imm;
        2'b10:   val2 = $unsigned($signed(bus.val_rm_in) >>> shift_imm);
        default: val2 = ror(bus.val_rm_in, rm_rot);
      endcase
    end
  end

  // One adder serves all four arithmetic ops; subtraction is Rn + ~Val2 + cin.
  logic [WIDTH-1:0] opb;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    opb = val2;
    cin = 1'b0;
    case (bus.exe_cmd_in)
      CMD_ADC: cin = status_reg[1];
      CMD_SUB: begin opb = ~val2; cin = 1'b1;          end
      CMD_SBC: begin opb = ~val2; cin = status_reg[1]; end
      default: ;
    endcase
    sum = {1'b0, bus.val_rn_in} + {1'b0, opb} + (WIDTH+1)'(cin);

    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.exe_cmd_in)
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.val_rn_in[WIDTH-1] == opb[WIDTH-1]) &&
                  (sum[WIDTH-1] != bus.val_rn_in[WIDTH-1]);
      end
      CMD_AND: alu_res = bus.val_rn_in & val2;
      CMD_ORR: alu_res = bus.val_rn_in | val2;
      CMD_EOR: alu_res = bus.val_rn_in ^ val2;
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      default: alu_res = '0;
    endcase
  end

  logic [WIDTH-1:0] acc_step;
  assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    mcand_next     = mcand_reg;
    mplier_next    = mplier_reg;
    acc_next       = acc_reg;
    rm_hold_next   = rm_hold_reg;
    dest_hold_next = dest_hold_reg;
    ctl_hold_next  = ctl_hold_reg;
    out_valid_next = 1'b0;
    wb_en_next     = 1'b0;
    mem_r_next     = 1'b0;
    mem_w_next     = 1'b0;
    alu_res_next   = alu_res_reg;
    val_rm_next    = val_rm_reg;
    dest_next      = dest_reg;
    status_next    = status_reg;
    busy_int       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!bus.flush && bus.in_valid) begin
          if (bus.exe_cmd_in == CMD_MUL) begin
            busy_int       = 1'b1;
            state_next     = MUL;
            mcand_next     = bus.val_rn_in;
            mplier_next    = bus.val_rm_in;
            acc_next       = '0;
            cnt_next       = '0;
            rm_hold_next   = bus.val_rm_in;
            dest_hold_next = bus.dest_in;
            ctl_hold_next  = {bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in, bus.s_in};
          end else begin
            out_valid_next = 1'b1;
            wb_en_next     = bus.wb_en_in;
            mem_r_next     = bus.mem_r_en_in;
            mem_w_next     = bus.mem_w_en_in;
            alu_res_next   = alu_res;
            val_rm_next    = bus.val_rm_in;
            dest_next      = bus.dest_in;
            if (bus.s_in) begin
              status_next = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
            end
          end
        end
      end
      MUL: begin
        if (bus.flush) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          acc_next    = acc_step;
          mcand_next  = mcand_reg << 1;
          mplier_next = mplier_reg >> 1;
          cnt_next    = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_LAST) begin
            state_next     = IDLE;
            cnt_next       = '0;
            out_valid_next = 1'b1;
            wb_en_next     = ctl_hold_reg[3];
            mem_r_next     = ctl_hold_reg[2];
            mem_w_next     = ctl_hold_reg[1];
            alu_res_next   = acc_step;
            val_rm_next    = rm_hold_reg;
            dest_next      = dest_hold_reg;
            // MUL leaves C and V untouched
            if (ctl_hold_reg[0]) begin
              status_next = {acc_step[WIDTH-1], acc_step == '0, status_reg[1:0]};
            end
          end else begin
            busy_int = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      rm_hold_reg   <= '0;
      dest_hold_reg <= '0;
      ctl_hold_reg  <= '0;
      out_valid_reg <= 1'b0;
      wb_en_reg     <= 1'b0;
      mem_r_reg     <= 1'b0;
      mem_w_reg     <= 1'b0;
      alu_res_reg   <= '0;
      val_rm_reg    <= '0;
      dest_reg      <= '0;
      status_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      mcand_reg     <= mcand_next;
      mplier_reg    <= mplier_next;
      acc_reg       <= acc_next;
      rm_hold_reg   <= rm_hold_next;
      dest_hold_reg <= dest_hold_next;
      ctl_hold_reg  <= ctl_hold_next;
      out_valid_reg <= out_valid_next;
      wb_en_reg     <= wb_en_next;
      mem_r_reg     <= mem_r_next;
      mem_w_reg     <= mem_w_next;
      alu_res_reg   <= alu_res_next;
      val_rm_reg    <= val_rm_next;
      dest_reg      <= dest_next;
      status_reg    <= status_next;
    end
  end

  logic signed [25:0] br_off;
  assign br_off = {bus.imm24_in, 2'b00};

  assign bus.busy         = rst & busy_int;
  assign bus.out_valid    = out_valid_reg;
  assign bus.wb_en_out    = wb_en_reg;
  assign bus.mem_r_en_out = mem_r_reg;
  assign bus.mem_w_en_out = mem_w_reg;
  assign bus.alu_res_out  = alu_res_reg;
  assign bus.val_rm_out   = val_rm_reg;
  assign bus.dest_out     = dest_reg;
  assign bus.status_out   = status_reg;
  assign bus.branch_taken = bus.b_in & bus.in_valid & ~bus.flush;
  assign bus.branch_addr  = bus.pc_in + WIDTH'(br_off);
endmodule

// File: doc/exe_stage_mc.md
# exe_stage_mc

Parametrised multi-cycle execute stage for the pipelined ARM core. It sits between the ID/EX register and the MEM stage. It generates Val2 with the full shifter and immediate-rotate rules, runs the ALU, and owns the NZCV status register that was previously held outside the stage. It adds a WIDTH-cycle shift-add multiplier (EXE_CMD 1010) with a busy handshake, and drives a registered EXE/MEM output bundle with flush support.

## Interface
- WIDTH, 32, datapath width; must be ≥16 and a multiple of 8.
- CNT_W, $clog2(WIDTH), width of the multiply step counter.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of the current stage contents (taken branch).
- in_valid  in  1  the ID/EX register holds a real instruction.
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, i_in  in  1 each  control bits from decode.
- exe_cmd_in  in  4  ALU command: MOV 0001, MVN 1001, ADD/LDR/STR 0010, ADC 0011, SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111, EOR 1000, MUL 1010.
- pc_in, val_rn_in, val_rm_in  in  WIDTH each  operands.
- shift_operand_in  in  12  shifter field.
- imm24_in  in  24  branch offset.
- dest_in  in  4  destination register.
- busy  out  1  combinational; while high, upstream holds the ID/EX register.
- out_valid, wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered.
- alu_res_out, val_rm_out  out  WIDTH each  registered.
- dest_out  out  4  registered.
- status_out  out  4  NZCV register: [3]N [2]Z [1]C [0]V.
- branch_taken  out  1  combinational: b_in & in_valid & ~flush.
- branch_addr  out  WIDTH  combinational: pc_in + (sign-extended imm24_in << 2), modulo 2^WIDTH.

## Operation
- **Val2 generation**
  - If mem_r_en_in | mem_w_en_in: Val2 is shift_operand_in zero-extended.
  - Else if i_in: Val2 is imm8 ([7:0]) rotated right by 2·rot ([11:8]), taken mod WIDTH.
  - Else: Val2 is val_rm_in shifted by shift_imm ([11:7]) using type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes the value unchanged.
- **ALU**
  - Carry-in for ADC and SBC is status C. SBC computes Rn − Val2 − ~C.
  - C: carry out for add ops; NOT borrow for sub ops.
  - V: signed overflow on ADD, ADC, SUB and SBC.
  - Logical and move ops force C = 0 and V = 0.
  - N is bit WIDTH−1 of the result. Z is set when the result is 0.
- **FSM**, states IDLE and MUL:
  - IDLE, in_valid, cmd ≠ MUL: the result is registered at the next edge with out_valid = 1.
  - IDLE, in_valid, cmd = MUL: load multiplicand = val_rn_in, multiplier = val_rm_in, acc = 0, cnt = 0. Go to MUL. busy = 1 in this cycle.
  - MUL, each cycle: if multiplier[0], acc += multiplicand. Then shift multiplicand left by 1, shift multiplier right by 1, increment cnt.
    - busy = 1 while cnt ≠ WIDTH−1.
    - At cnt = WIDTH−1, busy = 0. The low WIDTH bits of the final acc are registered as alu_res_out with out_valid = 1, and the FSM returns to IDLE.
  - In any cycle where no result is registered, the output bundle is a bubble: out_valid, wb_en_out, mem_r_en_out and mem_w_en_out are all 0.
- **Status register**
  - Written at the same edge the result registers, only when s_in = 1 and no flush.
  - MUL updates N and Z only; C and V are preserved.
  - A following instruction always sees the updated status.
- **Pass-through fields**: val_rm_out and dest_out register together with the result.

## Timing
- **Reset** (rst low, asynchronous): state = IDLE, cnt = 0, status_out = 0000, all registered outputs = 0. busy = 0 while reset is held.
- **Latency**
  - Non-MUL: 1 cycle.
  - MUL: busy is high for WIDTH cycles, and the result registers at the end of cycle WIDTH (WIDTH+1 edges after it is first presented).
- **Back-to-back**: non-MUL instructions sustain one per cycle.
- **Flush** has priority over everything. At that edge: FSM → IDLE, any multiply is aborted, the output bundle becomes a bubble, and status is not written. busy is forced low in a flush cycle.
- **Reset mid-multiply**: the partial product is discarded and no result is produced.
- **in_valid = 0 in IDLE**: a bubble is registered and status holds.
- **Operand changes during MUL**: changes on val_* while busy are ignored, because the operands were latched at acceptance.

## Test plan
- **Reset and ADD**: reset, then ADD with Rn = 5, Val2 = immediate 3, S = 1 → next edge alu_res_out = 8, out_valid = 1, status_out = 0000.
- **SUB flags, ADC carry, then MOV**
  - SUB Rn = 0x80000000, Rm = 1, S = 1 → result 0x7FFFFFFF, status_out = 0011 (C = 1, V = 1).
  - Then ADC with Rn = 1 and Val2 = 1 → result 3.
  - Then MOV from immediate imm8 = 0xFF, rot = 4 → 0xFF000000.
- **Rm shifts**: Rm = 0x80000001.
  - ASR #1 → 0xC0000000.
  - ROR #4 → 0x18000000.
  - LSR #31 → 1.
- **MUL, WIDTH = 32**: Rn = 7, Rm = 0xFFFFFFFF, S = 1, status C = 1 beforehand.
  - busy is high for exactly 32 cycles.
  - The result 0xFFFFFFF9 registers at the 33rd edge, with N = 1, Z = 0, and C = 1 preserved.
- **Flush mid-multiply**: assert flush in the 10th MUL cycle → busy drops the same cycle, the next output is a bubble, status is unchanged, and the following ADD completes in 1 cycle.
- **Branch and async reset**
  - b_in = 1, pc_in = 0x100, imm24 = 0xFFFFFE → branch_addr = 0x0F8 and branch_taken = 1 in the same cycle.
  - rst pulsed low between clock edges during a multiply → outputs clear immediately and busy = 0.
